alu_request_arbiter: RTL and testbench
======================================

# alu_request_arbiter

Sequencer and round-robin arbiter that shares one add/subtract datapath between two operation requesters. It accepts one request at a time over a valid/ready handshake and issues a one-cycle start pulse with registered operands to the shared datapath. It then waits for the datapath's done strobe, with a timeout, and returns the result, carry and requester id over a valid/ready response port. It sits between the operand/button front-end logic and the shared adder/subtractor, upstream of display formatting.

## Interface

Parameters:
- WIDTH, 4, operand/result width
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before error response (≥1)

Ports:
- i_w_clk  in  1  clock; all logic on rising edge
- i_w_reset  in  1  synchronous, active-high reset
- i_w_req0_valid / i_w_req1_valid  in  1  request pending from requester 0 / 1
- i_w_req0_a, i_w_req0_b / i_w_req1_a, i_w_req1_b  in  WIDTH  operands A, B per requester
- i_w_req0_sub / i_w_req1_sub  in  1  0 = add, 1 = subtract
- o_w_req0_ready / o_w_req1_ready  out  1  grant; request accepted when valid && ready
- o_r_dp_a, o_r_dp_b  out  WIDTH  operands to datapath (held from ISSUE through WAIT)
- o_r_dp_sub  out  1  operation select to datapath
- o_r_dp_start  out  1  one-cycle start pulse
- i_w_dp_result  in  WIDTH  datapath result
- i_w_dp_carry  in  1  datapath carry/borrow
- i_w_dp_done  in  1  result valid strobe
- o_r_rsp_valid  out  1  response available
- o_r_rsp_data  out  WIDTH  captured result
- o_r_rsp_carry  out  1  captured carry/borrow
- o_r_rsp_id  out  1  requester that issued the operation
- o_r_rsp_error  out  1  1 = datapath timeout
- i_w_rsp_ready  in  1  consumer accepts response
- o_r_err_count  out  8  saturating timeout count
- o_w_busy  out  1  high in any state except IDLE

## Operation

- States: IDLE, ISSUE, WAIT, RESPOND. Encoding is free.
- IDLE:
  - ready is combinational.
  - If only reqN_valid is high, reqN_ready = 1.
  - If both are high, the requester other than last_grant gets ready; the other requester's ready = 0.
  - On accept: register a, b, sub and id; last_grant <= id; next state ISSUE.
- ISSUE:
  - o_r_dp_start = 1 for exactly this cycle; o_r_dp_a/b/sub are valid.
  - Next state WAIT; timeout counter cleared to 0.
  - i_w_dp_done is ignored in ISSUE.
- WAIT:
  - If i_w_dp_done = 1: capture result and carry; rsp_error = 0; next state RESPOND.
  - Otherwise the counter increments. If the counter was TIMEOUT_CYCLES-1: rsp_data = 0, rsp_carry = 0, rsp_error = 1, err_count increments (saturates at 255), next state RESPOND.
  - Done arriving on the final counted cycle is a success, not an error.
- RESPOND:
  - o_r_rsp_valid = 1; data, carry, id and error are held stable.
  - On i_w_rsp_ready = 1: rsp_valid drops the next cycle; next state IDLE.
- Both req ready outputs are 0 in every state except IDLE; at most one request is in flight.
- Arithmetic is performed externally; this block passes WIDTH bits plus carry unchanged.
- Reset (any state, including mid-operation):
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All o_r_* outputs = 0, err_count = 0, and any in-flight operation or pending response is discarded.
  - A late i_w_dp_done after reset is ignored.

## Timing

- Request accepted at edge T → o_r_dp_start high in cycle T+1.
- Datapath done in cycle T+1+L, where L ≥ 1 → o_r_rsp_valid high from cycle T+2+L.
- Minimum accept-to-response latency is 3 cycles.
- Response handshake completes in cycle R → earliest next accept is in cycle R+1, since IDLE is re-entered at R+1.
- Timeout: with no done, the WAIT cycles are T+2 … T+1+TIMEOUT_CYCLES → error response valid at T+2+TIMEOUT_CYCLES.
- Requester valid may drop without being accepted; there is no state side effect.
- Operands are sampled only on the accept edge.

## Test plan

- Single add: req0 a=9, b=8, sub=0, accepted at T; datapath model with L=2 returns 1, carry 1 → start at T+1, rsp_valid at T+4 with data=1, carry=1, id=0, error=0.
- Fairness: both requesters hold valid continuously and rsp_ready=1 → grants are 0,1,0,1, and the rsp_id sequence matches.
- Backpressure: rsp_ready held 0 for 5 cycles in RESPOND → response fields stable, both ready outputs 0, no second start pulse; release → IDLE next cycle.
- Subtract: req1 a=3, b=5, sub=1; model returns 4'hE with borrow → data=E, carry as supplied, id=1; o_r_dp_sub=1 during ISSUE/WAIT.
- Timeout: done never asserted → rsp at T+17 with error=1, data=0, err_count=1. Done asserted on the 15th WAIT cycle instead → error=0.
- Reset mid-WAIT: assert i_w_reset for 1 cycle → next cycle all outputs 0 and busy=0. A done pulse 2 cycles later produces no response; the next tie grants requester 0.

Source files
------------

// File: rtl/alu_request_arbiter_if.sv
// alu_request_arbiter_if
// Bundles every non-clock, non-reset signal of alu_request_arbiter.
//   requests : i_w_reqN_valid/a/b/sub in, o_w_reqN_ready out (N = 0, 1)
//   datapath : o_r_dp_a/b/sub/start out, i_w_dp_result/carry/done in
//   response : o_r_rsp_valid/data/carry/id/error out, i_w_rsp_ready in
//   status   : o_r_err_count (saturating timeouts), o_w_busy
// The slave modport is the arbiter side; master is the surrounding logic.
interface alu_request_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             i_w_req0_valid;
  logic [WIDTH-1:0] i_w_req0_a;
  logic [WIDTH-1:0] i_w_req0_b;
  logic             i_w_req0_sub;
  logic             o_w_req0_ready;
  logic             i_w_req1_valid;
  logic [WIDTH-1:0] i_w_req1_a;
  logic [WIDTH-1:0] i_w_req1_b;
  logic             i_w_req1_sub;
  logic             o_w_req1_ready;
  logic [WIDTH-1:0] o_r_dp_a;
  logic [WIDTH-1:0] o_r_dp_b;
  logic             o_r_dp_sub;
  logic             o_r_dp_start;
  logic [WIDTH-1:0] i_w_dp_result;
  logic             i_w_dp_carry;
  logic             i_w_dp_done;
  logic             o_r_rsp_valid;
  logic [WIDTH-1:0] o_r_rsp_data;
  logic             o_r_rsp_carry;
  logic             o_r_rsp_id;
  logic             o_r_rsp_error;
  logic             i_w_rsp_ready;
  logic [7:0]       o_r_err_count;
  logic             o_w_busy;

  modport slave (
    input  i_w_req0_valid, i_w_req0_a, i_w_req0_b, i_w_req0_sub,
    input  i_w_req1_valid, i_w_req1_a, i_w_req1_b, i_w_req1_sub,
    output o_w_req0_ready, o_w_req1_ready,
    output o_r_dp_a, o_r_dp_b, o_r_dp_sub, o_r_dp_start,
    input  i_w_dp_result, i_w_dp_carry, i_w_dp_done,
    output o_r_rsp_valid, o_r_rsp_data, o_r_rsp_carry, o_r_rsp_id, o_r_rsp_error,
    input  i_w_rsp_ready,
    output o_r_err_count, o_w_busy
  );

  modport master (
    output i_w_req0_valid, i_w_req0_a, i_w_req0_b, i_w_req0_sub,
    output i_w_req1_valid, i_w_req1_a, i_w_req1_b, i_w_req1_sub,
    input  o_w_req0_ready, o_w_req1_ready,
    input  o_r_dp_a, o_r_dp_b, o_r_dp_sub, o_r_dp_start,
    output i_w_dp_result, i_w_dp_carry, i_w_dp_done,
    input  o_r_rsp_valid, o_r_rsp_data, o_r_rsp_carry, o_r_rsp_id, o_r_rsp_error,
    output i_w_rsp_ready,
    input  o_r_err_count, o_w_busy
  );
endinterface

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter
// Round-robin sequencer sharing one external add/subtract datapath between
// two requesters. One operation is in flight at a time:
//   IDLE -> ISSUE (one-cycle start) -> WAIT (done or timeout) -> RESPOND.
// Ports:
//   i_w_clk   : clock, rising edge
//   i_w_reset : synchronous active-high reset
//   bus       : alu_request_arbiter_if.slave (requests, datapath, response,
//               error count, busy)
module alu_request_arbiter #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  alu_request_arbiter_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [WIDTH-1:0] dp_a_reg, dp_b_reg;
  logic             dp_sub_reg, dp_start_reg;
  logic [CW-1:0]    wait_count_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_carry_reg, rsp_id_reg, rsp_error_reg;
  logic [7:0]       err_count_reg;

  logic grant0, grant1, accept, done_ok, timed_out;

  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    accept     = 1'b0;
    done_ok    = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (bus.i_w_req0_valid && bus.i_w_req1_valid) begin
          grant0 = last_grant_reg;
          grant1 = ~last_grant_reg;
        end else begin
          grant0 = bus.i_w_req0_valid;
          grant1 = bus.i_w_req1_valid;
        end
        accept = grant0 | grant1;
        if (accept) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // Done takes priority, so done on the last counted cycle succeeds.
        if (bus.i_w_dp_done) begin
          done_ok    = 1'b1;
          state_next = RESPOND;
        end else if (wait_count_reg == LAST_WAIT) begin
          timed_out  = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: if (bus.i_w_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      dp_a_reg       <= '0;
      dp_b_reg       <= '0;
      dp_sub_reg     <= 1'b0;
      dp_start_reg   <= 1'b0;
      wait_count_reg <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_error_reg  <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      // Start is high exactly during the ISSUE cycle that follows an accept.
      dp_start_reg  <= accept;
      rsp_valid_reg <= (state_next == RESPOND);
      if (accept) begin
        dp_a_reg       <= grant1 ? bus.i_w_req1_a   : bus.i_w_req0_a;
        dp_b_reg       <= grant1 ? bus.i_w_req1_b   : bus.i_w_req0_b;
        dp_sub_reg     <= grant1 ? bus.i_w_req1_sub : bus.i_w_req0_sub;
        rsp_id_reg     <= grant1;
        last_grant_reg <= grant1;
      end
      if (state_reg == ISSUE) begin
        wait_count_reg <= '0;
      end else if (state_reg == WAIT) begin
        wait_count_reg <= wait_count_reg + 1'b1;
      end
      if (done_ok) begin
        rsp_data_reg  <= bus.i_w_dp_result;
        rsp_carry_reg <= bus.i_w_dp_carry;
        rsp_error_reg <= 1'b0;
      end else if (timed_out) begin
        rsp_data_reg  <= '0;
        rsp_carry_reg <= 1'b0;
        rsp_error_reg <= 1'b1;
        if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign bus.o_w_req0_ready = grant0;
  assign bus.o_w_req1_ready = grant1;
  assign bus.o_r_dp_a       = dp_a_reg;
  assign bus.o_r_dp_b       = dp_b_reg;
  assign bus.o_r_dp_sub     = dp_sub_reg;
  assign bus.o_r_dp_start   = dp_start_reg;
  assign bus.o_r_rsp_valid  = rsp_valid_reg;
  assign bus.o_r_rsp_data   = rsp_data_reg;
  assign bus.o_r_rsp_carry  = rsp_carry_reg;
  assign bus.o_r_rsp_id     = rsp_id_reg;
  assign bus.o_r_rsp_error  = rsp_error_reg;
  assign bus.o_r_err_count  = err_count_reg;
  assign bus.o_w_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter
// Directed bench for alu_request_arbiter: a cycle-level transaction model
// (accept cycle, response cycle, captured values) is compared against the
// DUT every cycle; directed scenarios add hand-computed literal checks.
module tb_alu_request_arbiter;
  localparam int WIDTH = 4;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_request_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_request_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_w_clk  (clk),
    .i_w_reset(rst),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- external datapath model ----------------
  int               dp_lat = 1;     // 0 = never answers
  int               dp_due = -1;
  int               manual_due = -1;
  logic [WIDTH-1:0] dp_res_q = '0;
  logic             dp_carry_q = 1'b0;

  initial begin
    logic [WIDTH:0] wide;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_r_dp_start) begin
        if (bus.o_r_dp_sub) wide = {1'b0, bus.o_r_dp_a} - {1'b0, bus.o_r_dp_b};
        else                wide = {1'b0, bus.o_r_dp_a} + {1'b0, bus.o_r_dp_b};
        dp_res_q   = wide[WIDTH-1:0];
        dp_carry_q = wide[WIDTH];
        dp_due     = (dp_lat > 0) ? cyc + dp_lat : -1;
      end
    end
  end

  initial begin
    bus.i_w_dp_done   = 1'b0;
    bus.i_w_dp_result = '0;
    bus.i_w_dp_carry  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_w_dp_done   = (cyc == dp_due) || (cyc == manual_due);
      bus.i_w_dp_result = dp_res_q;
      bus.i_w_dp_carry  = dp_carry_q;
    end
  end

  // ---------------- transaction model + compare ----------------
  bit               m_active = 0, m_last = 1, m_post_reset = 0;
  int               m_acc = 0, m_rsp_from = -1, m_errcnt = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;
  bit               m_sub = 0, m_id = 0, m_carry = 0, m_err = 0;

  initial begin
    bit e_r0, e_r1, e_valid, w;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 0; m_last = 1; m_errcnt = 0; m_rsp_from = -1; m_post_reset = 1;
      end else begin
        e_r0 = 0; e_r1 = 0;
        if (!m_active) begin
          if (bus.i_w_req0_valid && bus.i_w_req1_valid) begin
            w = ~m_last; e_r0 = ~w; e_r1 = w;
          end else begin
            e_r0 = bus.i_w_req0_valid; e_r1 = bus.i_w_req1_valid;
          end
        end
        e_valid = m_active && (m_rsp_from >= 0) && (cyc >= m_rsp_from);
        chk("req0_ready", bus.o_w_req0_ready, e_r0);
        chk("req1_ready", bus.o_w_req1_ready, e_r1);
        chk("busy", bus.o_w_busy, m_active);
        chk("dp_start", bus.o_r_dp_start, m_active && (cyc == m_acc + 1));
        chk("rsp_valid", bus.o_r_rsp_valid, e_valid);
        chk("err_count", bus.o_r_err_count, m_errcnt);
        if (m_active) chk("dp_operands", {bus.o_r_dp_a, bus.o_r_dp_b, bus.o_r_dp_sub}, {m_a, m_b, m_sub});
        if (e_valid) chk("rsp_fields", {bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_id, bus.o_r_rsp_error},
                         {m_data, m_carry, m_id, m_err});
        if (m_post_reset) chk("post_reset_zero", {bus.o_r_dp_a, bus.o_r_dp_b, bus.o_r_dp_sub, bus.o_r_rsp_data,
                              bus.o_r_rsp_carry, bus.o_r_rsp_id, bus.o_r_rsp_error}, 0);
        m_post_reset = 0;
        // advance the model by this cycle's inputs
        if (m_active && m_rsp_from < 0) begin
          if (cyc >= m_acc + 2 && bus.i_w_dp_done) begin
            m_rsp_from = cyc + 1; m_data = bus.i_w_dp_result; m_carry = bus.i_w_dp_carry; m_err = 0;
          end else if (cyc == m_acc + 1 + TMO) begin
            m_rsp_from = cyc + 1; m_data = '0; m_carry = 0; m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
          end
        end else if (m_active) begin
          if (cyc >= m_rsp_from && bus.i_w_rsp_ready) m_active = 0;
        end else if (e_r0 || e_r1) begin
          m_active = 1; m_acc = cyc; m_rsp_from = -1; m_id = e_r1; m_last = e_r1;
          m_a   = e_r1 ? bus.i_w_req1_a   : bus.i_w_req0_a;
          m_b   = e_r1 ? bus.i_w_req1_b   : bus.i_w_req0_b;
          m_sub = e_r1 ? bus.i_w_req1_sub : bus.i_w_req0_sub;
        end
      end
    end
  end

  // ---------------- DUT-side monitor ----------------
  int grants[$];
  int rsp_ids[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.i_w_req0_valid && bus.o_w_req0_ready) grants.push_back(0);
        if (bus.i_w_req1_valid && bus.o_w_req1_ready) grants.push_back(1);
        if (bus.o_r_rsp_valid && bus.i_w_rsp_ready) begin
          rsp_ids.push_back(int'(bus.o_r_rsp_id));
          $display("txn cycle=%0d id=%0d data=%h carry=%0d error=%0d err_count=%0d", cyc,
                   bus.o_r_rsp_id, bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_error, bus.o_r_err_count);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit sub, output int acc);
    if (id == 1'b0) begin
      bus.i_w_req0_valid = 1'b1; bus.i_w_req0_a = a; bus.i_w_req0_b = b; bus.i_w_req0_sub = sub;
    end else begin
      bus.i_w_req1_valid = 1'b1; bus.i_w_req1_a = a; bus.i_w_req1_b = b; bus.i_w_req1_sub = sub;
    end
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && bus.o_w_req0_ready) || (id == 1'b1 && bus.o_w_req1_ready)) acc = cyc;
      step();
    end
    if (id == 1'b0) bus.i_w_req0_valid = 1'b0;
    else            bus.i_w_req1_valid = 1'b0;
    chk("accepted", acc >= 0, 1'b1);
  endtask

  task automatic wait_rsp(output int r);
    r = -1;
    for (int i = 0; i < 60 && r < 0; i++) begin
      @(negedge clk);
      if (bus.o_r_rsp_valid) r = cyc;
    end
    chk("rsp_seen", r >= 0, 1'b1);
  endtask

  initial begin
    int t, r, r2;
    bus.i_w_req0_valid = 0; bus.i_w_req0_a = '0; bus.i_w_req0_b = '0; bus.i_w_req0_sub = 0;
    bus.i_w_req1_valid = 0; bus.i_w_req1_a = '0; bus.i_w_req1_b = '0; bus.i_w_req1_sub = 0;
    bus.i_w_rsp_ready  = 1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.o_w_busy, 0);
    chk("reset_outputs", {bus.o_r_rsp_valid, bus.o_r_dp_start, bus.o_r_err_count}, 0);
    step();

    // Fairness: both requesters hold valid; first tie goes to requester 0.
    dp_lat = 1;
    grants.delete(); rsp_ids.delete();
    bus.i_w_req0_a = 4'd1; bus.i_w_req0_b = 4'd2; bus.i_w_req0_sub = 0;
    bus.i_w_req1_a = 4'd7; bus.i_w_req1_b = 4'd4; bus.i_w_req1_sub = 1;
    bus.i_w_req0_valid = 1; bus.i_w_req1_valid = 1;
    for (int i = 0; i < 200 && rsp_ids.size() < 4; i++) step();
    bus.i_w_req0_valid = 0; bus.i_w_req1_valid = 0;
    chk("fair_grant_count", grants.size(), 4);
    chk("fair_rsp_count", rsp_ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size())  chk("fair_grant_id", grants[i], i % 2);
      if (i < rsp_ids.size()) chk("fair_rsp_id", rsp_ids[i], i % 2);
    end
    step();

    // Single add 9+8, latency 2: response 4 cycles after accept, data 1 carry 1.
    dp_lat = 2;
    do_req(0, 4'd9, 4'd8, 0, t);
    wait_rsp(r);
    chk("add_latency", r, t + 4);
    chk("add_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_id, bus.o_r_rsp_error}, {4'h1, 1'b1, 1'b0, 1'b0});
    step();

    // Subtract 3-5 from requester 1, latency 3.
    dp_lat = 3;
    do_req(1, 4'd3, 4'd5, 1, t);
    @(negedge clk);
    chk("sub_issue_start", bus.o_r_dp_start, 1);
    chk("sub_issue_sel", bus.o_r_dp_sub, 1);
    wait_rsp(r);
    chk("sub_latency", r, t + 5);
    chk("sub_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_id, bus.o_r_rsp_error}, {4'hE, 1'b1, 1'b1, 1'b0});
    step();

    // Backpressure: response held 5 cycles while requester 1 waits.
    dp_lat = 1;
    bus.i_w_rsp_ready = 0;
    do_req(0, 4'd2, 4'd3, 0, t);
    bus.i_w_req1_a = 4'd6; bus.i_w_req1_b = 4'd1; bus.i_w_req1_sub = 0; bus.i_w_req1_valid = 1;
    wait_rsp(r);
    chk("bp_latency", r, t + 3);
    for (int k = 1; k <= 4; k++) begin
      step();
      @(negedge clk);
      chk("bp_hold", {bus.o_r_rsp_valid, bus.o_r_rsp_data, bus.o_r_rsp_id, bus.o_r_rsp_error}, {1'b1, 4'h5, 1'b0, 1'b0});
      chk("bp_no_grant", {bus.o_w_req0_ready, bus.o_w_req1_ready, bus.o_r_dp_start}, 0);
    end
    step();
    bus.i_w_rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", bus.o_r_rsp_valid, 1);
    step();
    @(negedge clk);
    chk("bp_idle_busy", bus.o_w_busy, 0);
    chk("bp_idle_grant1", bus.o_w_req1_ready, 1);
    t = cyc;
    step();
    bus.i_w_req1_valid = 0;
    wait_rsp(r2);
    chk("bp_next_latency", r2, t + 3);
    chk("bp_next_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_id}, {4'h7, 1'b1});
    step();

    // Timeout: datapath never answers.
    dp_lat = 0;
    do_req(1, 4'd1, 4'd1, 0, t);
    wait_rsp(r);
    chk("tmo_latency", r, t + 17);
    chk("tmo_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_error}, {4'h0, 1'b0, 1'b1});
    chk("tmo_err_count", bus.o_r_err_count, 1);
    step();

    // Done on the 15th WAIT cycle is still a success.
    dp_lat = 15;
    do_req(0, 4'd4, 4'd4, 0, t);
    wait_rsp(r);
    chk("late_done_latency", r, t + 17);
    chk("late_done_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_carry, bus.o_r_rsp_error}, {4'h8, 1'b0, 1'b0});
    chk("late_done_err_count", bus.o_r_err_count, 1);
    step();

    // Reset mid-WAIT, then a stale done pulse, then a tie.
    dp_lat = 0;
    do_req(0, 4'd5, 4'd5, 0, t);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    manual_due = cyc + 2;
    @(negedge clk);
    chk("rst_mid_busy", bus.o_w_busy, 0);
    chk("rst_mid_outputs", {bus.o_r_rsp_valid, bus.o_r_dp_start, bus.o_r_err_count, bus.o_r_dp_a,
                            bus.o_r_dp_b, bus.o_r_rsp_data, bus.o_r_rsp_error}, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("rst_no_rsp", {bus.o_r_rsp_valid, bus.o_w_busy}, 0);
    end
    step();
    dp_lat = 1;
    bus.i_w_req0_a = 4'd3; bus.i_w_req0_b = 4'd3; bus.i_w_req0_sub = 0;
    bus.i_w_req1_a = 4'd2; bus.i_w_req1_b = 4'd2; bus.i_w_req1_sub = 0;
    bus.i_w_req0_valid = 1; bus.i_w_req1_valid = 1;
    @(negedge clk);
    chk("rst_tie_grant", {bus.o_w_req0_ready, bus.o_w_req1_ready}, 2'b10);
    step();
    bus.i_w_req0_valid = 0; bus.i_w_req1_valid = 0;
    wait_rsp(r);
    chk("rst_tie_rsp", {bus.o_r_rsp_data, bus.o_r_rsp_id}, {4'h6, 1'b0});
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
